// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor with an integrated control FSM.
// Operands are taken through a valid/ready handshake. They are processed
// LSB-first, one bit per clock, through a single carry flip-flop. The result
// is returned in parallel together with carry and signed-overflow flags.
//
// Sequence: IDLE -> (accept) -> LOAD -> SHIFT x WIDTH -> DONE -> IDLE/LOAD
//
// Parameters:
//   WIDTH  operand/result width, 2..64
//   CNT_W  bit-counter width (derived; do not override)
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     asynchronous active-high reset
//   in_valid_i  operands and mode valid
//   in_ready_o  block can accept (IDLE and DONE)
//   a_i, b_i    operands
//   sub_i       0 = A+B, 1 = A-B
//   acc_i       (optional) use the current sum_o as operand A
//   busy_o      high in LOAD or SHIFT
//   shift_en_o  high on each SHIFT cycle
//   sum_bit_o   current serial sum bit (valid while shift_en_o is high)
//   sum_o       parallel result, held until the next accept
//   carry_o     final carry out (for subtract, 1 = no borrow)
//   overflow_o  two's-complement overflow of the last operation
//   done_o      one-cycle pulse; result registers are valid from this cycle
//
// Optional feature macro: SERIAL_ADDSUB_ACCUM_EN
//   When it is defined, the acc_i port exists. With acc_i = 1 at accept,
//   operand A is loaded from sum_o instead of a_i, which gives a serial
//   accumulator.
// ---------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
`ifdef SERIAL_ADDSUB_ACCUM_EN
  input  logic             acc_i,
`endif
  output logic             busy_o,
  output logic             shift_en_o,
  output logic             sum_bit_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Only WIDTH-1 partial bits are kept. The last bit goes straight into r_sum.
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_mode;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_shift_en;
  logic             r_done;

  logic             w_accept;
  logic             w_sum_bit;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_full;
  logic [WIDTH-1:0] w_a_load;
  logic [WIDTH-1:0] w_b_load;

  assign w_accept   = in_valid_i & r_in_ready;
  assign w_sum_bit  = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_cout     = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) |
                      (r_b_sr[0] & r_carry);
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));
  // Result register after this shift: the new bit enters at the MSB.
  assign w_res_full = {w_sum_bit, r_res};
  // Subtraction is A + ~B + 1. The +1 arrives through the carry seeded in LOAD.
  assign w_b_load   = sub_i ? ~b_i : b_i;

`ifdef SERIAL_ADDSUB_ACCUM_EN
  assign w_a_load = acc_i ? r_sum : a_i;
`else
  assign w_a_load = a_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_mode      <= 1'b0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a_sr     <= w_a_load;
            r_b_sr     <= w_b_load;
            r_mode     <= sub_i;
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_LOAD: begin
          r_carry    <= r_mode;
          r_count    <= '0;
          r_state    <= ST_SHIFT;
          r_shift_en <= 1'b1;
        end

        ST_SHIFT: begin
          r_carry <= w_cout;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_res   <= w_res_full[WIDTH-1:1];
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            // MSB cycle: r_carry is the carry into the MSB, w_cout the carry out.
            r_sum       <= w_res_full;
            r_carry_out <= w_cout;
            r_ovf       <= r_carry ^ w_cout;
            r_state     <= ST_DONE;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end

        ST_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            // Back-to-back: a new operation starts without passing through IDLE.
            r_a_sr     <= w_a_load;
            r_b_sr     <= w_b_load;
            r_mode     <= sub_i;
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_shift_en <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = r_in_ready;
  assign busy_o     = r_busy;
  assign shift_en_o = r_shift_en;
  assign done_o     = r_done;
  assign sum_bit_o  = w_sum_bit;
  assign sum_o      = r_sum;
  assign carry_o    = r_carry_out;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Self-checking bench for serial_addsub (WIDTH = 8).
// When an operation is driven, its expected result is pushed to a scoreboard
// queue. When done_o pulses, the entry is popped and compared with the DUT.
// ---------------------------------------------------------------------------
module tb_serial_addsub;
  localparam int WIDTH = 8;
  localparam int CLK_P = 10;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             acc_i;
  logic             busy_o;
  logic             shift_en_o;
  logic             sum_bit_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             done_o;

  always #(CLK_P/2) clk_i = ~clk_i;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .sub_i      (sub_i),
`ifdef SERIAL_ADDSUB_ACCUM_EN
    .acc_i      (acc_i),
`endif
    .busy_o     (busy_o),
    .shift_en_o (shift_en_o),
    .sum_bit_o  (sum_bit_o),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o),
    .done_o     (done_o)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    time              t_acc;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  time              done_t[$];
  int               checks     = 0;
  int               errors     = 0;
  int               pushes     = 0;
  int               done_seen  = 0;
  int               shift_cnt  = 0;
  int               ready_viol = 0;
  logic [WIDTH-1:0] model_sum  = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares every done_o pulse against the scoreboard.
  always @(negedge clk_i) begin
    if (reset_i) begin
      shift_cnt  = 0;
      ready_viol = 0;
    end else begin
      if (shift_en_o) shift_cnt++;
      if (busy_o && in_ready_o) ready_viol++;
      if (done_o) begin
        done_seen++;
        done_t.push_back($time);
        if (sb_q.size() == 0) begin
          check_eq("done_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("op done: sum=0x%0h carry=%0b ovf=%0b (exp 0x%0h %0b %0b)",
                   sum_o, carry_o, overflow_o, mon_e.sum, mon_e.carry, mon_e.ovf);
          check_eq("sum", sum_o, mon_e.sum);
          check_eq("carry", carry_o, mon_e.carry);
          check_eq("overflow", overflow_o, mon_e.ovf);
          check_eq("latency", ($time + CLK_P/2 - mon_e.t_acc) / CLK_P, WIDTH + 2);
          check_eq("shift_cycles", shift_cnt, WIDTH);
          check_eq("ready_while_busy", ready_viol, 0);
          check_eq("ready_in_done", in_ready_o, 1);
        end
        shift_cnt  = 0;
        ready_viol = 0;
      end
    end
  end

  // Drives one operation and waits for its accept edge.
  // keep_valid leaves in_valid_i high, so the next call is accepted in DONE.
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic acc,
                          input bit expect_done, input bit keep_valid);
    int               n;
    exp_t             item;
    logic [WIDTH-1:0] aa;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 64'd0, 64'd1);
    a_i        = a;
    b_i        = b;
    sub_i      = sub;
    acc_i      = acc;
    in_valid_i = 1'b1;
    aa   = acc ? model_sum : a;
    bb   = sub ? ~b : b;
    full = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    @(posedge clk_i);
    if (expect_done) begin
      item.sum   = full[WIDTH-1:0];
      item.carry = full[WIDTH];
      item.ovf   = (aa[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != aa[WIDTH-1]);
      item.t_acc = $time;
      sb_q.push_back(item);
      pushes++;
      model_sum = full[WIDTH-1:0];
    end
    if (!keep_valid) begin
      #1 in_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("drain_queue", sb_q.size(), 0);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset_i    = 1'b1;
    in_valid_i = 1'b0;
    a_i        = '0;
    b_i        = '0;
    sub_i      = 1'b0;
    acc_i      = 1'b0;
    @(negedge clk_i);
    check_eq("rst_sum", sum_o, 0);
    check_eq("rst_carry", carry_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_shift_en", shift_en_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1 check_eq("rst_ready", in_ready_o, 1);

    // Basic add, wrap-around, signed overflow and subtract cases
    drive_op(8'h35, 8'h4A, 1'b0, 1'b0, 1, 0); drain();
    drive_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 0); drain();
    drive_op(8'h7F, 8'h01, 1'b0, 1'b0, 1, 0); drain();
    drive_op(8'h80, 8'h01, 1'b1, 1'b0, 1, 0); drain();
    drive_op(8'h05, 8'h07, 1'b1, 1'b0, 1, 0); drain();

    // Back-to-back with in_valid_i held high
    done_t.delete();
    drive_op(8'h12, 8'h34, 1'b0, 1'b0, 1, 1);
    drive_op(8'hC8, 8'h64, 1'b1, 1'b0, 1, 1);
    drive_op(8'h9A, 8'hBC, 1'b0, 1'b0, 1, 0);
    drain();
    check_eq("b2b_done_count", done_t.size(), 3);
    if (done_t.size() >= 3) begin
      check_eq("b2b_spacing1", done_t[1] - done_t[0], (WIDTH + 2) * CLK_P);
      check_eq("b2b_spacing2", done_t[2] - done_t[1], (WIDTH + 2) * CLK_P);
    end

    // Reset on the 4th shift cycle
    drive_op(8'h11, 8'h22, 1'b0, 1'b0, 0, 0);
    n = 0;
    k = 0;
    while (k < 4 && n < 50) begin
      @(negedge clk_i);
      n++;
      if (shift_en_o) k++;
    end
    check_eq("rst_mid_reach", k, 4);
    reset_i = 1'b1;
    #1;
    check_eq("mid_rst_sum", sum_o, 0);
    check_eq("mid_rst_carry", carry_o, 0);
    check_eq("mid_rst_ovf", overflow_o, 0);
    check_eq("mid_rst_done", done_o, 0);
    check_eq("mid_rst_busy", busy_o, 0);
    check_eq("mid_rst_shift_en", shift_en_o, 0);
    model_sum = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1 check_eq("mid_rst_ready", in_ready_o, 1);
    drive_op(8'h10, 8'h20, 1'b0, 1'b0, 1, 0); drain();

    // Random operations
    for (int i = 0; i < 6; i++) begin
      drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1, 0);
    end
    drain();

`ifdef SERIAL_ADDSUB_ACCUM_EN
    // Accumulator sequence: 0x07, 0x0C, 0x0B
    drive_op(8'h03, 8'h04, 1'b0, 1'b0, 1, 0); drain();
    check_eq("acc_step1", model_sum, 8'h07);
    drive_op(8'h00, 8'h05, 1'b0, 1'b1, 1, 0); drain();
    check_eq("acc_step2", sum_o, 8'h0C);
    drive_op(8'h00, 8'h01, 1'b1, 1'b1, 1, 0); drain();
    check_eq("acc_step3", sum_o, 8'h0B);
`endif

    check_eq("done_count", done_seen, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
